// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
// Time-multiplexed scan controller for a bank of 7-segment digits that share a
// single BCD-to-7-segment decoder. One digit is driven per scan slot, most
// significant digit first. Adds leading-zero suppression, whole-display blink,
// lamp test, forced blanking and tear-free value updates at frame boundaries.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   load            : one-cycle strobe, captures value_in into the shadow value
//   value_in        : NUM_DIGITS BCD nibbles, nibble 0 is least significant
//   blank_lead      : suppress leading zeros
//   blink_en        : blink the whole display
//   lamp_test       : light all segments
//   display_off     : force the display dark
//   bcd_out         : digit code to the decoder
//   lt_out/rbi_out/bi_out : decoder lamp-test / ripple-blank / blank inputs
//   digit_sel       : one-hot active-high digit enable
//   frame_done      : one-cycle pulse after the last slot of a frame
//   update_pending  : shadow value waiting to be committed
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_SCANS = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    blank_lead,
  input  logic                    blink_en,
  input  logic                    lamp_test,
  input  logic                    display_off,
  output logic [3:0]              bcd_out,
  output logic                    lt_out,
  output logic                    rbi_out,
  output logic                    bi_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done,
  output logic                    update_pending
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  // State registers
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         active_q, active_d;
  logic [VW-1:0]         shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic                  zero_run_q, zero_run_d;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;

  // Registered outputs
  logic [3:0]            bcd_q, bcd_d;
  logic                  lt_q, lt_d;
  logic                  rbi_q, rbi_d;
  logic                  bi_q, bi_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  fd_q, fd_d;

  logic                  tick_s;
  logic                  frame_end_s;
  logic [3:0]            digit_s;
  logic                  lead_zero_s;

  // Next-state and next-output logic
  always_comb begin
    tick_s      = (presc_q == PW'(SCAN_DIV - 1));
    frame_end_s = tick_s && (idx_q == {IW{1'b0}});
    digit_s     = active_q[4*idx_q +: 4];
    // zero_run means every higher digit of this frame was zero; digit 0 is always shown
    lead_zero_s = blank_lead && zero_run_q && (digit_s == 4'd0) && (idx_q != {IW{1'b0}});

    if (tick_s) begin
      presc_d = {PW{1'b0}};
    end else begin
      presc_d = presc_q + PW'(1);
    end

    idx_d         = idx_q;
    zero_run_d    = zero_run_q;
    active_d      = active_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_end_s) begin
      idx_d      = IW'(NUM_DIGITS - 1);
      zero_run_d = 1'b1;
      // A load landing on the frame end supersedes the old shadow, so skip commit
      if (pending_q && !load) begin
        active_d = shadow_q;
      end else begin
        active_d = active_q;
      end
      if (blink_cnt_q == BW'(BLINK_SCANS - 1)) begin
        blink_cnt_d   = {BW{1'b0}};
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q;
      end
    end else if (tick_s) begin
      idx_d      = idx_q - IW'(1);
      zero_run_d = zero_run_q && (digit_s == 4'd0);
    end else begin
      idx_d      = idx_q;
      zero_run_d = zero_run_q;
    end

    if (load) begin
      shadow_d  = value_in;
      pending_d = 1'b1;
    end else if (frame_end_s) begin
      shadow_d  = shadow_q;
      pending_d = 1'b0;
    end else begin
      shadow_d  = shadow_q;
      pending_d = pending_q;
    end

    // Decoder priority: BI over LT over blink/RBI
    sel_d = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
    bcd_d = digit_s;
    lt_d  = lamp_test;
    rbi_d = lead_zero_s && !lamp_test;
    bi_d  = display_off || (blink_en && blink_phase_q && !lamp_test);
    fd_d  = frame_end_s;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q       <= {PW{1'b0}};
      idx_q         <= IW'(NUM_DIGITS - 1);
      active_q      <= {VW{1'b0}};
      shadow_q      <= {VW{1'b0}};
      pending_q     <= 1'b0;
      zero_run_q    <= 1'b1;
      blink_cnt_q   <= {BW{1'b0}};
      blink_phase_q <= 1'b0;
      bcd_q         <= 4'd0;
      lt_q          <= 1'b0;
      rbi_q         <= 1'b0;
      bi_q          <= 1'b1;
      sel_q         <= {NUM_DIGITS{1'b0}};
      fd_q          <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      zero_run_q    <= zero_run_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      bcd_q         <= bcd_d;
      lt_q          <= lt_d;
      rbi_q         <= rbi_d;
      bi_q          <= bi_d;
      sel_q         <= sel_d;
      fd_q          <= fd_d;
    end
  end

  assign bcd_out        = bcd_q;
  assign lt_out         = lt_q;
  assign rbi_out        = rbi_q;
  assign bi_out         = bi_q;
  assign digit_sel      = sel_q;
  assign frame_done     = fd_q;
  assign update_pending = pending_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for display_scan_ctrl (NUM_DIGITS=4, SCAN_DIV=4, BLINK_SCANS=2).
// The reference model tracks only a cycle count since reset plus the
// displayed/shadow values; slot, digit, frame and blink phase are derived
// arithmetically from that count.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BS = 2;
  localparam int FL = ND * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value_in;
  logic        blank_lead;
  logic        blink_en;
  logic        lamp_test;
  logic        display_off;
  logic [3:0]  bcd_out;
  logic        lt_out;
  logic        rbi_out;
  logic        bi_out;
  logic [3:0]  digit_sel;
  logic        frame_done;
  logic        update_pending;

  always #5 clk = ~clk;

  display_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_SCANS(BS)) dut (
    .clk(clk), .rst(rst), .load(load), .value_in(value_in),
    .blank_lead(blank_lead), .blink_en(blink_en), .lamp_test(lamp_test),
    .display_off(display_off), .bcd_out(bcd_out), .lt_out(lt_out),
    .rbi_out(rbi_out), .bi_out(bi_out), .digit_sel(digit_sel),
    .frame_done(frame_done), .update_pending(update_pending)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  int          n;
  logic [15:0] m_active;
  logic [15:0] m_shadow;
  logic        m_pending;
  logic [12:0] exp_v;
  logic [12:0] obs;
  assign obs = {digit_sel, bcd_out, lt_out, rbi_out, bi_out, frame_done, update_pending};

  // Compute the expected outputs for this cycle, advance the model, clock once.
  task automatic step();
    int idx;
    logic [3:0] d;
    logic lz, ph, fe;
    if (rst) begin
      exp_v = {4'b0000, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      n = 0; m_active = 16'h0; m_shadow = 16'h0; m_pending = 1'b0;
    end else begin
      idx = ND - 1 - ((n / SD) % ND);
      d   = 4'((m_active >> (4 * idx)) & 16'h000F);
      lz  = blank_lead && (idx != 0) && ((m_active >> (4 * idx)) == 16'h0);
      ph  = (((n / FL) / BS) % 2) == 1;
      fe  = (n % FL) == FL - 1;
      if (load) begin
        m_shadow = value_in; m_pending = 1'b1;
      end else if (fe && m_pending) begin
        m_active = m_shadow; m_pending = 1'b0;
      end
      exp_v = {4'(1 << idx), d, lamp_test, lz & ~lamp_test,
               display_off | (blink_en & ph & ~lamp_test), fe, m_pending};
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; value_in = 16'h0; blank_lead = 1'b0;
    blink_en = 1'b0; lamp_test = 1'b0; display_off = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (obs !== exp_v) begin failures++; $display("FAIL reset cyc=%0d got=%b exp=%b", i, obs, exp_v); end
      checks++;
    end
    rst = 1'b0;
    step();
    if (obs !== exp_v) begin failures++; $display("FAIL release got=%b exp=%b", obs, exp_v); end
    checks++;
    if (digit_sel !== 4'b1000 || bi_out !== 1'b0) begin
      failures++; $display("FAIL release_msd got sel=%b bi=%b exp sel=1000 bi=0", digit_sel, bi_out);
    end
    checks++;
  endtask

  task automatic test_scan();
    int pulses = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (frame_done === 1'b1) pulses++;
      if (obs !== exp_v) begin failures++; $display("FAIL scan n=%0d got=%b exp=%b", n, obs, exp_v); end
      checks++;
    end
    if (pulses != 2) begin failures++; $display("FAIL frame_pulses got=%0d exp=2", pulses); end
    checks++;
  endtask

  task automatic test_update();
    for (int i = 0; i < FL && (n % FL) != 5; i++) step();
    value_in = 16'h1234; load = 1'b1;
    step();
    load = 1'b0;
    if (update_pending !== 1'b1) begin failures++; $display("FAIL update_pending got=%b exp=1", update_pending); end
    checks++;
    for (int i = 0; i < 40; i++) begin
      step();
      if (obs !== exp_v) begin failures++; $display("FAIL update n=%0d got=%b exp=%b", n, obs, exp_v); end
      checks++;
    end
  endtask

  task automatic test_leading_zero();
    logic [15:0] vals [3];
    vals[0] = 16'h0050; vals[1] = 16'h0000; vals[2] = 16'h00A0;
    blank_lead = 1'b1;
    for (int v = 0; v < 3; v++) begin
      value_in = vals[v]; load = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 36; i++) begin
        step();
        if (obs !== exp_v) begin failures++; $display("FAIL lead_zero v=%h n=%0d got=%b exp=%b", vals[v], n, obs, exp_v); end
        checks++;
      end
    end
    blank_lead = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (obs !== exp_v) begin failures++; $display("FAIL lead_zero_off n=%0d got=%b exp=%b", n, obs, exp_v); end
      checks++;
    end
  endtask

  task automatic test_blink_priority();
    blink_en = 1'b1; blank_lead = 1'b1; value_in = 16'h0007; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (obs !== exp_v) begin failures++; $display("FAIL blink n=%0d got=%b exp=%b", n, obs, exp_v); end
      checks++;
    end
    lamp_test = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (obs !== exp_v) begin failures++; $display("FAIL lamp n=%0d got=%b exp=%b", n, obs, exp_v); end
      checks++;
    end
    display_off = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (obs !== exp_v) begin failures++; $display("FAIL off n=%0d got=%b exp=%b", n, obs, exp_v); end
      checks++;
    end
    blink_en = 1'b0; lamp_test = 1'b0; display_off = 1'b0; blank_lead = 1'b0;
  endtask

  task automatic test_collision();
    for (int i = 0; i < FL && (n % FL) != 3; i++) step();
    value_in = 16'h1111; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < FL && (n % FL) != FL - 1; i++) step();
    value_in = 16'h9999; load = 1'b1;
    step();
    load = 1'b0;
    if (update_pending !== 1'b1) begin failures++; $display("FAIL collision_pending got=%b exp=1", update_pending); end
    checks++;
    for (int i = 0; i < 36; i++) begin
      step();
      if (digit_sel != 4'b0000 && bcd_out === 4'h1) begin
        failures++; $display("FAIL collision_discard n=%0d got bcd=1 exp not 1", n);
      end
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL collision n=%0d got=%b exp=%b", n, obs, exp_v); end
      checks++;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < FL && (n % FL) != 0; i++) step();
    value_in = 16'h4321; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < FL && (n % FL) != 8; i++) step();
    rst = 1'b1;
    step();
    if (obs !== exp_v) begin failures++; $display("FAIL reset_mid got=%b exp=%b", obs, exp_v); end
    checks++;
    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (obs !== exp_v) begin failures++; $display("FAIL after_reset n=%0d got=%b exp=%b", n, obs, exp_v); end
      checks++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 15) == 0) blank_lead = ~blank_lead;
      if ($urandom_range(0, 31) == 0) blink_en = ~blink_en;
      if ($urandom_range(0, 47) == 0) lamp_test = ~lamp_test;
      if ($urandom_range(0, 63) == 0) display_off = ~display_off;
      load = ($urandom_range(0, 9) == 0);
      value_in = 16'($urandom);
      if ($urandom_range(0, 3) != 0) value_in = value_in & 16'h0F0F;
      rst = ($urandom_range(0, 299) == 0);
      step();
      if (obs !== exp_v) begin failures++; $display("FAIL random n=%0d got=%b exp=%b", n, obs, exp_v); end
      checks++;
    end
    load = 1'b0; rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_update();
    test_leading_zero();
    test_blink_priority();
    test_collision();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
